// File: rtl/instr_feeder.sv
// instr_feeder: steps through a small program memory and issues each
// instruction (and, for MVI, its immediate word) to a processor, waiting
// for Done between instructions. Outputs are registered from the next-state
// decode so that they change in step with the state register.
module instr_feeder #(
    parameter int         AW      = 5,
    parameter int         TIMEOUT = 4,
    parameter logic [2:0] MVI_OP  = 3'b001,
    parameter logic [2:0] HALT_OP = 3'b111
) (
    input  logic          clock,
    input  logic          aResetn,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [8:0]    prog_data,
    input  logic          Done,
    output logic          Run,
    output logic [8:0]    DataOut,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          error,
    output logic [7:0]    instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [AW-1:0] PC_ONE   = AW'(1);

    // Program memory (deliberately not reset so a program survives aResetn)
    logic [8:0]    mem_r [0:(2**AW)-1];

    state_t        state_r, state_nx_s;
    logic [AW-1:0] pc_r, pc_nx_s;
    logic [8:0]    ir_r, ir_nx_s;
    logic [TW-1:0] tmo_r, tmo_nx_s;
    logic [7:0]    cnt_r, cnt_nx_s;
    logic          err_r, err_nx_s;
    logic          run_r, run_nx_s;
    logic [8:0]    dout_r, dout_nx_s;
    logic          busy_r, halted_r;
    logic          we_ok_s;
    logic [8:0]    fetch_word_s;
    logic [8:0]    next_word_s;

    // Writes are only accepted while the feeder is not executing
    assign we_ok_s      = prog_we && ((state_r == ST_IDLE) || (state_r == ST_HALT));
    assign fetch_word_s = mem_r[pc_r];
    assign next_word_s  = mem_r[pc_nx_s];

    // Program memory write port
    always_ff @(posedge clock) begin
        if (we_ok_s) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // Next-state, program counter, IR, timeout and counter decode
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        ir_nx_s    = ir_r;
        tmo_nx_s   = tmo_r;
        cnt_nx_s   = cnt_r;
        err_nx_s   = err_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                // a write in the same cycle wins over start
                if (start && !prog_we) begin
                    state_nx_s = ST_FETCH;
                    pc_nx_s    = {AW{1'b0}};
                    err_nx_s   = 1'b0;
                    cnt_nx_s   = 8'd0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_FETCH: begin
                if (fetch_word_s[8:6] == HALT_OP) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_EXEC;
                    ir_nx_s    = fetch_word_s;
                    pc_nx_s    = pc_r + PC_ONE;
                    tmo_nx_s   = {TW{1'b0}};
                end
            end
            ST_EXEC: begin
                if (Done) begin
                    state_nx_s = ST_FETCH;
                    tmo_nx_s   = {TW{1'b0}};
                    if (cnt_r != 8'hFF) begin
                        cnt_nx_s = cnt_r + 8'd1;
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                    // pc already points at the immediate; step over it
                    if (ir_r[8:6] == MVI_OP) begin
                        pc_nx_s = pc_r + PC_ONE;
                    end else begin
                        pc_nx_s = pc_r;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_nx_s = ST_HALT;
                    err_nx_s   = 1'b1;
                    tmo_nx_s   = {TW{1'b0}};
                end else begin
                    tmo_nx_s   = tmo_r + TMO_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so they can be registered.
    // Memory is never written on an edge that enters FETCH or EXEC, so the
    // look-ahead read sees the same word the new state will see.
    always_comb begin
        run_nx_s  = 1'b0;
        dout_nx_s = 9'd0;
        case (state_nx_s)
            ST_FETCH: begin
                if (next_word_s[8:6] != HALT_OP) begin
                    run_nx_s  = 1'b1;
                    dout_nx_s = next_word_s;
                end else begin
                    run_nx_s  = 1'b0;
                    dout_nx_s = 9'd0;
                end
            end
            ST_EXEC: begin
                if (ir_nx_s[8:6] == MVI_OP) begin
                    dout_nx_s = next_word_s;
                end else begin
                    dout_nx_s = 9'd0;
                end
            end
            default: begin
                run_nx_s  = 1'b0;
                dout_nx_s = 9'd0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by aResetn
    always_ff @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            state_r  <= ST_IDLE;
            pc_r     <= {AW{1'b0}};
            ir_r     <= 9'd0;
            tmo_r    <= {TW{1'b0}};
            cnt_r    <= 8'd0;
            err_r    <= 1'b0;
            run_r    <= 1'b0;
            dout_r   <= 9'd0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            pc_r     <= pc_nx_s;
            ir_r     <= ir_nx_s;
            tmo_r    <= tmo_nx_s;
            cnt_r    <= cnt_nx_s;
            err_r    <= err_nx_s;
            run_r    <= run_nx_s;
            dout_r   <= dout_nx_s;
            busy_r   <= (state_nx_s == ST_FETCH) || (state_nx_s == ST_EXEC);
            halted_r <= (state_nx_s == ST_HALT);
        end
    end

    assign Run         = run_r;
    assign DataOut     = dout_r;
    assign pc          = pc_r;
    assign busy        = busy_r;
    assign halted      = halted_r;
    assign error       = err_r;
    assign instr_count = cnt_r;

endmodule
